// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module      : multicycle_controller_if
// Description : Control bundle between the multicycle sequencer and the
//               datapath / shared instruction-data memory.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multicycle_controller_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;

    modport master (
        input  Op, Funct, zero, mem_ready,
        output mem_req, memwrite, iord, irwrite, pcwrite, pcsrc,
               alusrca, alusrcb, alucontrol, regwrite, regdst, memtoreg, illegal
    );

    modport slave (
        output Op, Funct, zero, mem_ready,
        input  mem_req, memwrite, iord, irwrite, pcwrite, pcsrc,
               alusrca, alusrcb, alucontrol, regwrite, regdst, memtoreg, illegal
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module      : multicycle_controller
// Description : Moore sequencing FSM for the multicycle MIPS datapath with a
//               request/ready memory handshake. Optional MC_PERF_CNT_EN adds
//               the retired-instruction counter inst_cnt.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_controller (
    input  wire logic                clk,
    input  wire logic                rst,
    multicycle_controller_if.master  bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]              inst_cnt
`endif
);

    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_RTYP = 6'b000000;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam logic [5:0] c_OP_J    = 6'b000010;

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXE   = 4'd6,
        S_RTWB    = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEXE = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JMP     = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic       w_mem_req;
    logic       w_memwrite;
    logic       w_iord;
    logic       w_irwrite;
    logic       w_pcwrite;
    logic [1:0] w_pcsrc;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [2:0] w_alucontrol;
    logic       w_regwrite;
    logic       w_regdst;
    logic       w_memtoreg;
    logic       w_illegal;

    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_memwrite   = 1'b0;
        w_iord       = 1'b0;
        w_irwrite    = 1'b0;
        w_pcwrite    = 1'b0;
        w_pcsrc      = 2'b00;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_alucontrol = 3'b000;
        w_regwrite   = 1'b0;
        w_regdst     = 1'b0;
        w_memtoreg   = 1'b0;
        w_illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_alusrcb    = 2'b01;
                w_alucontrol = c_ALU_ADD;
                // IR and PC+4 commit only on the cycle the fetch completes
                if (bus.mem_ready) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alusrcb    = 2'b11;
                w_alucontrol = c_ALU_ADD;
                case (bus.Op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYP:        w_next = S_RTEXE;
                    c_OP_BEQ:         w_next = S_BEQ;
                    c_OP_ADDI:        w_next = S_ADDIEXE;
                    c_OP_J:           w_next = S_JMP;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_alucontrol = c_ALU_ADD;
                w_next       = (bus.Op == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_req  = 1'b1;
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_RTEXE: begin
                w_alusrca = 1'b1;
                // Unsupported Funct codes fall back to add without flagging
                case (bus.Funct)
                    6'b100010: w_alucontrol = c_ALU_SUB;
                    6'b100100: w_alucontrol = c_ALU_AND;
                    6'b100101: w_alucontrol = c_ALU_OR;
                    6'b101010: w_alucontrol = c_ALU_SLT;
                    default:   w_alucontrol = c_ALU_ADD;
                endcase
                w_next = S_RTWB;
            end
            S_RTWB: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQ: begin
                w_alusrca    = 1'b1;
                w_alucontrol = c_ALU_SUB;
                w_pcsrc      = 2'b01;
                w_pcwrite    = bus.zero;
                w_next       = S_FETCH;
            end
            S_ADDIEXE: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_alucontrol = c_ALU_ADD;
                w_next       = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_JMP: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Reset gates every output so an in-flight memory request is dropped at once
    assign bus.mem_req    = rst & w_mem_req;
    assign bus.memwrite   = rst & w_memwrite;
    assign bus.iord       = rst & w_iord;
    assign bus.irwrite    = rst & w_irwrite;
    assign bus.pcwrite    = rst & w_pcwrite;
    assign bus.pcsrc      = rst ? w_pcsrc : 2'b00;
    assign bus.alusrca    = rst & w_alusrca;
    assign bus.alusrcb    = rst ? w_alusrcb : 2'b00;
    assign bus.alucontrol = rst ? w_alucontrol : 3'b000;
    assign bus.regwrite   = rst & w_regwrite;
    assign bus.regdst     = rst & w_regdst;
    assign bus.memtoreg   = rst & w_memtoreg;
    assign bus.illegal    = rst & w_illegal;

`ifdef MC_PERF_CNT_EN
    logic [31:0] r_inst_cnt;
    logic        w_cnt_inc;

    // One count per instruction retired, i.e. every re-entry into FETCH
    assign w_cnt_inc = (r_state != S_FETCH) && (w_next == S_FETCH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst_cnt <= 32'd0;
        end else if (w_cnt_inc) begin
            r_inst_cnt <= r_inst_cnt + 32'd1;
        end
    end

    assign inst_cnt = r_inst_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench: directed vector table, reset corner
//               case and random instruction streams against a recipe model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    // Control vector: {mem_req,memwrite,iord,irwrite,pcwrite,pcsrc,alusrca,
    //                  alusrcb,alucontrol,regwrite,regdst,memtoreg,illegal}
    localparam logic [16:0] E_ZERO     = 17'd0;
    localparam logic [16:0] E_FETCH_GO = {5'b10011, 2'b00, 1'b0, 2'b01, 3'b010, 4'b0000};
    localparam logic [16:0] E_FETCH_WT = {5'b10000, 2'b00, 1'b0, 2'b01, 3'b010, 4'b0000};
    localparam logic [16:0] E_DEC      = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 4'b0000};
    localparam logic [16:0] E_DEC_ILL  = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 4'b0001};
    localparam logic [16:0] E_ADR      = {5'b00000, 2'b00, 1'b1, 2'b10, 3'b010, 4'b0000};
    localparam logic [16:0] E_RD       = {5'b10100, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000};
    localparam logic [16:0] E_LWB      = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b1010};
    localparam logic [16:0] E_WR       = {5'b11100, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000};
    localparam logic [16:0] E_RWB      = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b1100};
    localparam logic [16:0] E_AWB      = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b1000};
    localparam logic [16:0] E_BEQ1     = {5'b00001, 2'b01, 1'b1, 2'b00, 3'b110, 4'b0000};
    localparam logic [16:0] E_BEQ0     = {5'b00000, 2'b01, 1'b1, 2'b00, 3'b110, 4'b0000};
    localparam logic [16:0] E_JMP      = {5'b00001, 2'b10, 1'b0, 2'b00, 3'b000, 4'b0000};
    localparam logic [16:0] E_SUB      = {5'b00000, 2'b00, 1'b1, 2'b00, 3'b110, 4'b0000};
    localparam logic [16:0] E_SLT      = {5'b00000, 2'b00, 1'b1, 2'b00, 3'b111, 4'b0000};

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        mr;
        logic [16:0] exp;
    } row_t;

    typedef struct packed {
        logic [16:0] vec;
        logic        is_mem;
        logic        last;
    } step_t;

    logic clk;
    logic rst;
    logic [16:0] w_act;
    logic [31:0] inst_cnt;
    int checks;
    int errors;
    int exp_cnt;
    row_t tbl[$];

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MC_PERF_CNT_EN
        ,
        .inst_cnt(inst_cnt)
`endif
    );

`ifndef MC_PERF_CNT_EN
    assign inst_cnt = 32'd0;
`endif

    assign w_act = {bus.mem_req, bus.memwrite, bus.iord, bus.irwrite, bus.pcwrite,
                    bus.pcsrc, bus.alusrca, bus.alusrcb, bus.alucontrol,
                    bus.regwrite, bus.regdst, bus.memtoreg, bus.illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic row(input logic r, input logic [5:0] op, input logic [5:0] f,
                       input logic z, input logic mr, input logic [16:0] e);
        row_t t;
        t.rst = r; t.op = op; t.funct = f; t.zero = z; t.mr = mr; t.exp = e;
        tbl.push_back(t);
    endtask

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Per-instruction recipe: what the controller must show at each step
    function automatic step_t recipe(input int kind, input int step, input logic mr,
                                     input logic z, input logic [5:0] f);
        step_t s;
        s.vec = E_ZERO; s.is_mem = 1'b0; s.last = 1'b0;
        if (step == 0) begin
            s.vec = mr ? E_FETCH_GO : E_FETCH_WT;
            s.is_mem = 1'b1;
        end else if (step == 1) begin
            s.vec  = (kind == K_ILL) ? E_DEC_ILL : E_DEC;
            s.last = (kind == K_ILL);
        end else if (step == 2) begin
            case (kind)
                K_LW, K_SW, K_ADDI: s.vec = E_ADR;
                K_R:   s.vec = {5'b00000, 2'b00, 1'b1, 2'b00, alu_of(f), 4'b0000};
                K_BEQ: begin s.vec = z ? E_BEQ1 : E_BEQ0; s.last = 1'b1; end
                default: begin s.vec = E_JMP; s.last = 1'b1; end
            endcase
        end else if (step == 3) begin
            case (kind)
                K_LW:  begin s.vec = E_RD; s.is_mem = 1'b1; end
                K_SW:  begin s.vec = E_WR; s.is_mem = 1'b1; s.last = 1'b1; end
                K_R:   begin s.vec = E_RWB; s.last = 1'b1; end
                default: begin s.vec = E_AWB; s.last = 1'b1; end
            endcase
        end else begin
            s.vec  = E_LWB;
            s.last = 1'b1;
        end
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_outputs", {15'd0, w_act}, 32'd0);
`ifdef MC_PERF_CNT_EN
        chk("reset_cnt", inst_cnt, 32'd0);
`endif
        rst = 1'b1;
        exp_cnt = 0;
    endtask

    initial begin
        int unsigned rv;
        int kind, step, cyc;
        logic [5:0] op, f;
        logic done;
        step_t rs;

        checks = 0; errors = 0; exp_cnt = 0;
        rst = 1'b0;
        bus.Op = OP_LW; bus.Funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

        // Reset, lw, sub, slt, beq taken/not-taken, sw with waits, illegal
        for (int i = 0; i < 3; i++) row(0, OP_LW, 6'd0, 0, 1, E_ZERO);
        row(1, OP_LW, 6'd0, 0, 1, E_FETCH_GO);
        row(1, OP_LW, 6'd0, 0, 1, E_DEC);
        row(1, OP_LW, 6'd0, 0, 1, E_ADR);
        row(1, OP_LW, 6'd0, 0, 1, E_RD);
        row(1, OP_LW, 6'd0, 0, 1, E_LWB);
        row(1, OP_R, 6'b100010, 0, 1, E_FETCH_GO);
        row(1, OP_R, 6'b100010, 0, 1, E_DEC);
        row(1, OP_R, 6'b100010, 0, 1, E_SUB);
        row(1, OP_R, 6'b100010, 0, 1, E_RWB);
        row(1, OP_R, 6'b101010, 0, 1, E_FETCH_GO);
        row(1, OP_R, 6'b101010, 0, 1, E_DEC);
        row(1, OP_R, 6'b101010, 0, 1, E_SLT);
        row(1, OP_R, 6'b101010, 0, 1, E_RWB);
        row(1, OP_BEQ, 6'd0, 1, 1, E_FETCH_GO);
        row(1, OP_BEQ, 6'd0, 1, 1, E_DEC);
        row(1, OP_BEQ, 6'd0, 1, 1, E_BEQ1);
        row(1, OP_BEQ, 6'd0, 0, 1, E_FETCH_GO);
        row(1, OP_BEQ, 6'd0, 0, 1, E_DEC);
        row(1, OP_BEQ, 6'd0, 0, 1, E_BEQ0);
        row(1, OP_SW, 6'd0, 0, 0, E_FETCH_WT);
        row(1, OP_SW, 6'd0, 0, 0, E_FETCH_WT);
        row(1, OP_SW, 6'd0, 0, 1, E_FETCH_GO);
        row(1, OP_SW, 6'd0, 0, 1, E_DEC);
        row(1, OP_SW, 6'd0, 0, 1, E_ADR);
        row(1, OP_SW, 6'd0, 0, 0, E_WR);
        row(1, OP_SW, 6'd0, 0, 0, E_WR);
        row(1, OP_SW, 6'd0, 0, 0, E_WR);
        row(1, OP_SW, 6'd0, 0, 1, E_WR);
        row(1, 6'b111111, 6'd0, 0, 1, E_FETCH_GO);
        row(1, 6'b111111, 6'd0, 0, 1, E_DEC_ILL);
        row(1, 6'b111111, 6'd0, 0, 1, E_FETCH_GO);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst;
            bus.Op = tbl[i].op; bus.Funct = tbl[i].funct;
            bus.zero = tbl[i].zero; bus.mem_ready = tbl[i].mr;
            #1;
            chk($sformatf("table_row%0d", i), {15'd0, w_act}, {15'd0, tbl[i].exp});
`ifdef MC_PERF_CNT_EN
            if (i == 0) chk("table_reset_cnt", inst_cnt, 32'd0);
`endif
        end
`ifdef MC_PERF_CNT_EN
        chk("table_inst_cnt", inst_cnt, 32'd7);
`endif

        // Reset pulled mid-way through a stalled lw read
        do_reset();
        @(negedge clk); bus.Op = OP_LW; bus.mem_ready = 1'b1; #1;
        chk("midrst_fetch", {15'd0, w_act}, {15'd0, E_FETCH_GO});
        @(negedge clk); #1;
        chk("midrst_dec", {15'd0, w_act}, {15'd0, E_DEC});
        @(negedge clk); #1;
        chk("midrst_adr", {15'd0, w_act}, {15'd0, E_ADR});
        @(negedge clk); bus.mem_ready = 1'b0; #1;
        chk("midrst_rd", {15'd0, w_act}, {15'd0, E_RD});
        #2 rst = 1'b0;
        #1;
        chk("midrst_drop", {15'd0, w_act}, 32'd0);
        @(negedge clk); rst = 1'b1; #1;
        chk("midrst_refetch", {15'd0, w_act}, {15'd0, E_FETCH_WT});
`ifdef MC_PERF_CNT_EN
        chk("midrst_cnt", inst_cnt, 32'd0);
`endif

        // Random instruction streams with random wait states
        do_reset();
        for (int n = 0; n < 300; n++) begin
            rv   = $urandom;
            kind = int'(rv % 7);
            f    = 6'd0;
            case (kind)
                K_LW:   op = OP_LW;
                K_SW:   op = OP_SW;
                K_BEQ:  op = OP_BEQ;
                K_ADDI: op = OP_ADDI;
                K_J:    op = OP_J;
                K_R: begin
                    op = OP_R;
                    rv = $urandom;
                    case (rv % 6)
                        0: f = 6'b100000;
                        1: f = 6'b100010;
                        2: f = 6'b100100;
                        3: f = 6'b100101;
                        4: f = 6'b101010;
                        default: f = rv[13:8];
                    endcase
                end
                default: begin
                    do begin
                        rv = $urandom;
                        op = rv[5:0];
                    end while (op == OP_LW || op == OP_SW || op == OP_R ||
                               op == OP_BEQ || op == OP_ADDI || op == OP_J);
                end
            endcase
            step = 0; cyc = 0; done = 1'b0;
            while (!done) begin
                @(negedge clk);
                rv = $urandom;
                bus.Op = op; bus.Funct = f;
                bus.zero = rv[0];
                bus.mem_ready = (rv[2:1] != 2'b00);
                #1;
                rs = recipe(kind, step, bus.mem_ready, bus.zero, f);
                chk("rand_ctl", {15'd0, w_act}, {15'd0, rs.vec});
`ifdef MC_PERF_CNT_EN
                chk("rand_inst_cnt", inst_cnt, exp_cnt);
`endif
                if (rs.is_mem && !bus.mem_ready) begin
                    step = step;
                end else if (rs.last) begin
                    done = 1'b1;
                    exp_cnt++;
                end else begin
                    step++;
                end
                cyc++;
                if (!done && cyc > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_timeout: got %0d cycles expected at most 200", cyc);
                    done = 1'b1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle MIPS datapath. It replaces the single-cycle main/ALU decode with a Moore-style state machine that steps each instruction through fetch, decode, execute, memory and writeback over 3–5+ cycles. It drives a shared instruction/data memory through a request/ready handshake, so memory wait states stall the sequence. It supports lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Op  in  6  instruction[31:26], taken from the instruction register
- Funct  in  6  instruction[5:0], taken from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  write strobe, valid with mem_req
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  load the instruction register
- pcwrite  out  1  PC load enable; already includes branch & zero
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch), 10 = jump target
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- regwrite  out  1  register file write enable
- regdst  out  1  destination register: 1 = rd, 0 = rt
- memtoreg  out  1  writeback source: 1 = memory data register, 0 = ALUOut
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded

## Operation
- State register is 4 bits. States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, BEQ, ADDIEXE, ADDIWB, JMP.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00.
  - Holds until mem_ready=1.
  - On that cycle it pulses irwrite and pcwrite (PC+4), then goes to DECODE.
  - irwrite and pcwrite are 0 while waiting.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target into ALUOut). Next state by Op:
  - 100011 or 101011 → MEMADR
  - 000000 → RTEXE
  - 000100 → BEQ
  - 001000 → ADDIEXE
  - 000010 → JMP
  - any other → FETCH, with illegal=1 for that cycle
- MEMADR: alusrca=1, alusrcb=10, add. Goes to MEMRD if Op=100011, else MEMWR.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready, then → MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. → FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1. Holds until mem_ready, then → FETCH.
- RTEXE: alusrca=1, alusrcb=00. alucontrol from Funct:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - any other Funct → 010 (no illegal flag). → RTWB.
- RTWB: regwrite=1, regdst=1, memtoreg=0. → FETCH.
- BEQ: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcwrite=zero. → FETCH.
- ADDIEXE: alusrca=1, alusrcb=10, add. → ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. → FETCH.
- JMP: pcsrc=10, pcwrite=1. → FETCH.
- Any output not listed for a state is 0 in that state.

## Timing
- rst low: state forced to FETCH immediately (async). While rst is low, every output is gated to 0, including mem_req.
- First mem_req is asserted combinationally as soon as rst goes high.
- Outputs are combinational from state (plus Funct, zero and mem_ready where listed). No output registers.
- Cycle counts with zero-wait memory (mem_ready held high):
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal: 2
- Each wait cycle (mem_ready low while mem_req high) adds one cycle and holds all outputs constant.
- mem_ready is ignored when mem_req=0.
- Reset asserted mid-access: request dropped at once, state returns to FETCH. The memory must tolerate an abandoned request.
- Op and Funct must be stable from DECODE until return to FETCH. The IR is loaded only by irwrite.
- Unknown state encodings recover to FETCH on the next edge.

## Configuration
- MC_PERF_CNT_EN defined:
  - Adds output inst_cnt (32 bits). Reset to 0.
  - Increments by 1 on every transition into FETCH from any state other than FETCH; illegal opcodes are counted.
  - Wraps 0xFFFFFFFF → 0.
- MC_PERF_CNT_EN undefined: port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst=0 for 3 cycles with mem_ready=1 → all outputs 0. Release → first cycle shows mem_req=1, irwrite=1, pcwrite=1, alusrcb=01.
- lw, Op=100011, mem_ready=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite=1 and memtoreg=1 only in cycle 5.
- R-type sub, Op=000000, Funct=100010 → alucontrol=110 in RTEXE. regwrite=1, regdst=1 in cycle 4. Repeat for slt → alucontrol=111.
- beq: Op=000100 with zero=1 → pcwrite=1, pcsrc=01 in cycle 3. With zero=0 → pcwrite=0. Next cycle is FETCH in both cases.
- Wait states: sw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMWR → 9 cycles total. memwrite held high for all 4 MEMWR cycles.
- Op=111111 → illegal=1 in DECODE, back to FETCH next cycle. With MC_PERF_CNT_EN, inst_cnt increments by 1 (and by 6 after lw, sw, add, beq, addi, j).
